// File: rtl/st_video_pkg.sv
// Shared video timing constants: frame lengths, register-select encoding and
// the frame-length helper used by the mode controller.
package st_video_pkg;

  localparam logic [8:0] LINES_MONO = 9'd501;
  localparam logic [8:0] LINES_NTSC = 9'd263;
  localparam logic [8:0] LINES_PAL  = 9'd313;

  localparam logic SEL_SYNC = 1'b0;
  localparam logic SEL_RES  = 1'b1;

  localparam int VSYNC_LINES_DEF = 3;

  // Interlaced colour frames alternate a one-line-shorter odd field.
  function automatic logic [8:0] frame_len_f(input logic mono, input logic ntsc,
                                             input logic il, input logic fld);
    logic [8:0] len;
    if (mono)      len = LINES_MONO;
    else if (ntsc) len = LINES_NTSC;
    else           len = LINES_PAL;
    if (il && !mono && fld) len = len - 9'd1;
    return len;
  endfunction

endpackage

// File: rtl/vline_cnt.sv
// Vertical line counter with wrap compare, registered vsync and frame-start pulse.
module vline_cnt
  import st_video_pkg::*;
#(
  parameter int VSYNC_LINES = VSYNC_LINES_DEF
) (
  input  logic       m2clock,
  input  logic       resb,
  input  logic       hload,
  input  logic [8:0] frame_len,
  output logic [8:0] vsc,
  output logic       wrap,
  output logic       vsync_n,
  output logic       frame_start
);

  localparam logic [8:0] VS_END = 9'(VSYNC_LINES);

  logic [8:0] vsc_nxt;

  // >= rather than == so a mode change that shortens the frame wraps at once
  always_comb begin
    wrap    = hload && (vsc >= frame_len - 9'd1);
    vsc_nxt = vsc;
    if (wrap)       vsc_nxt = '0;
    else if (hload) vsc_nxt = vsc + 9'd1;
  end

  always_ff @(posedge m2clock or negedge resb) begin
    if (!resb) begin
      vsc         <= '0;
      vsync_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vsc         <= vsc_nxt;
      vsync_n     <= (vsc_nxt >= VS_END);
      frame_start <= wrap;
    end
  end

endmodule

// File: rtl/timing_mode_ctl.sv
// Video timing mode controller: CPU-written shadow mode registers applied at
// line/frame boundaries, driving the vertical line counter.
module timing_mode_ctl
  import st_video_pkg::*;
#(
  parameter int         VSYNC_LINES = VSYNC_LINES_DEF,
  parameter logic [1:0] MODE_RESET  = 2'b00
) (
  input  logic       m2clock,
  input  logic       resb,
  input  logic       cpu_we,
  input  logic       cpu_sel,
  input  logic [1:0] cpu_d,
  input  logic       hload,
  output logic       mde1,
  output logic       mde1b,
  output logic       ntsc,
  output logic       interlace,
  output logic [8:0] vsc,
  output logic       vsync_n,
  output logic       field,
  output logic       frame_start
);

  logic       sh_mono, sh_ntsc, sh_il;
  logic       eff_mono, eff_ntsc, eff_il;
  logic       wr_sync, wr_res;
  logic       wrap;
  logic [8:0] frame_len;

  assign wr_sync = cpu_we && (cpu_sel == SEL_SYNC);
  assign wr_res  = cpu_we && (cpu_sel == SEL_RES);

  // A write coinciding with an applying hload goes straight through
  assign eff_mono = wr_res  ? cpu_d[0] : sh_mono;
  assign eff_ntsc = wr_sync ? cpu_d[1] : sh_ntsc;
  assign eff_il   = wr_sync ? cpu_d[0] : sh_il;

  assign frame_len = frame_len_f(mde1, ntsc, interlace, field);
  assign mde1b     = ~mde1;

  always_ff @(posedge m2clock or negedge resb) begin
    if (!resb) begin
      sh_mono   <= 1'b0;
      sh_ntsc   <= MODE_RESET[1];
      sh_il     <= MODE_RESET[0];
      mde1      <= 1'b0;
      ntsc      <= MODE_RESET[1];
      interlace <= MODE_RESET[0];
      field     <= 1'b0;
    end else begin
      if (wr_sync) begin
        sh_ntsc <= cpu_d[1];
        sh_il   <= cpu_d[0];
      end
      if (wr_res) sh_mono <= cpu_d[0];
      if (hload)  mde1 <= eff_mono;
      if (wrap) begin
        ntsc      <= eff_ntsc;
        interlace <= eff_il;
        // field only alternates between two consecutive interlaced colour frames
        field     <= (interlace && !mde1 && eff_il && !eff_mono) ? ~field : 1'b0;
      end
    end
  end

  vline_cnt #(.VSYNC_LINES(VSYNC_LINES)) u_vline_cnt (
    .m2clock     (m2clock),
    .resb        (resb),
    .hload       (hload),
    .frame_len   (frame_len),
    .vsc         (vsc),
    .wrap        (wrap),
    .vsync_n     (vsync_n),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_timing_mode_ctl.sv
// Directed bench for timing_mode_ctl: frame lengths per mode, shadow apply
// timing, interlace fields, write-through and asynchronous reset.
module tb_timing_mode_ctl;

  logic       m2clock = 1'b0;
  logic       resb    = 1'b0;
  logic       cpu_we  = 1'b0;
  logic       cpu_sel = 1'b0;
  logic [1:0] cpu_d   = 2'b00;
  logic       hload   = 1'b0;
  logic       mde1, mde1b, ntsc, interlace, vsync_n, field, frame_start;
  logic [8:0] vsc;

  int checks = 0;
  int errors = 0;

  timing_mode_ctl dut (
    .m2clock     (m2clock),
    .resb        (resb),
    .cpu_we      (cpu_we),
    .cpu_sel     (cpu_sel),
    .cpu_d       (cpu_d),
    .hload       (hload),
    .mde1        (mde1),
    .mde1b       (mde1b),
    .ntsc        (ntsc),
    .interlace   (interlace),
    .vsc         (vsc),
    .vsync_n     (vsync_n),
    .field       (field),
    .frame_start (frame_start)
  );

  always #5 m2clock = ~m2clock;

  task automatic tick();
    @(posedge m2clock);
    #1;
  endtask

  task automatic do_hloads(input int n);
    for (int i = 0; i < n; i++) begin
      hload = 1'b1;
      tick();
      hload = 1'b0;
    end
  endtask

  task automatic write_reg(input logic sel, input logic [1:0] d);
    cpu_we = 1'b1; cpu_sel = sel; cpu_d = d;
    tick();
    cpu_we = 1'b0; cpu_d = 2'b00;
  endtask

  task automatic apply_reset();
    resb = 1'b0;
    tick(); tick();
    resb = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (vsc !== 9'd0 || field !== 1'b0 || vsync_n !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt vsc=%0d field=%b vsync_n=%b fs=%b want 0 0 0 0", vsc, field, vsync_n, frame_start);
    end
    checks++;
    if (mde1 !== 1'b0 || mde1b !== 1'b1 || ntsc !== 1'b0 || interlace !== 1'b0) begin
      errors++;
      $display("FAIL reset_mode mde1=%b mde1b=%b ntsc=%b il=%b want 0 1 0 0", mde1, mde1b, ntsc, interlace);
    end
  endtask

  task automatic test_pal_frame();
    int fs_seen;
    apply_reset();
    fs_seen = 0;
    for (int i = 1; i <= 312; i++) begin
      do_hloads(1);
      if (frame_start === 1'b1) fs_seen++;
      checks++;
      if (vsc !== 9'(i) || vsync_n !== ((i < 3) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL pal_line got vsc=%0d vsync_n=%b want vsc=%0d vsync_n=%b", vsc, vsync_n, i, (i < 3) ? 1'b0 : 1'b1);
      end
    end
    tick();
    checks++;
    if (vsc !== 9'd312) begin errors++; $display("FAIL pal_idle vsc=%0d want 312", vsc); end
    do_hloads(1);
    checks++;
    if (vsc !== 9'd0 || frame_start !== 1'b1 || vsync_n !== 1'b0 || fs_seen != 0) begin
      errors++;
      $display("FAIL pal_wrap vsc=%0d fs=%b vsync_n=%b early_fs=%0d want 0 1 0 0", vsc, frame_start, vsync_n, fs_seen);
    end
    tick();
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("FAIL pal_fs_width fs=%b want 0", frame_start); end
  endtask

  task automatic test_ntsc_switch();
    apply_reset();
    do_hloads(100);
    write_reg(1'b0, 2'b10);
    checks++;
    if (ntsc !== 1'b0) begin errors++; $display("FAIL ntsc_after_write ntsc=%b want 0", ntsc); end
    do_hloads(212);
    checks++;
    if (vsc !== 9'd312 || ntsc !== 1'b0) begin
      errors++; $display("FAIL ntsc_prewrap vsc=%0d ntsc=%b want 312 0", vsc, ntsc);
    end
    do_hloads(1);
    checks++;
    if (vsc !== 9'd0 || ntsc !== 1'b1 || interlace !== 1'b0) begin
      errors++; $display("FAIL ntsc_apply vsc=%0d ntsc=%b il=%b want 0 1 0", vsc, ntsc, interlace);
    end
    do_hloads(262);
    checks++;
    if (vsc !== 9'd262) begin errors++; $display("FAIL ntsc_last vsc=%0d want 262", vsc); end
    do_hloads(1);
    checks++;
    if (vsc !== 9'd0 || frame_start !== 1'b1) begin
      errors++; $display("FAIL ntsc_wrap vsc=%0d fs=%b want 0 1", vsc, frame_start);
    end
  endtask

  task automatic test_mono();
    apply_reset();
    do_hloads(50);
    write_reg(1'b1, 2'b11);
    checks++;
    if (mde1 !== 1'b0 || mde1b !== 1'b1) begin
      errors++; $display("FAIL mono_after_write mde1=%b mde1b=%b want 0 1", mde1, mde1b);
    end
    do_hloads(1);
    checks++;
    if (mde1 !== 1'b1 || mde1b !== 1'b0 || vsc !== 9'd51) begin
      errors++; $display("FAIL mono_apply mde1=%b mde1b=%b vsc=%0d want 1 0 51", mde1, mde1b, vsc);
    end
    do_hloads(449);
    checks++;
    if (vsc !== 9'd500) begin errors++; $display("FAIL mono_last vsc=%0d want 500", vsc); end
    do_hloads(1);
    checks++;
    if (vsc !== 9'd0 || frame_start !== 1'b1 || ntsc !== 1'b0 || interlace !== 1'b0) begin
      errors++;
      $display("FAIL mono_wrap vsc=%0d fs=%b ntsc=%b il=%b want 0 1 0 0", vsc, frame_start, ntsc, interlace);
    end
  endtask

  task automatic test_shorten();
    apply_reset();
    write_reg(1'b1, 2'b01);
    do_hloads(400);
    write_reg(1'b1, 2'b00);
    do_hloads(1);
    checks++;
    if (vsc !== 9'd401 || mde1 !== 1'b0) begin
      errors++; $display("FAIL shorten_step vsc=%0d mde1=%b want 401 0", vsc, mde1);
    end
    do_hloads(1);
    checks++;
    if (vsc !== 9'd0 || frame_start !== 1'b1) begin
      errors++; $display("FAIL shorten_wrap vsc=%0d fs=%b want 0 1", vsc, frame_start);
    end
  endtask

  task automatic test_interlace();
    apply_reset();
    write_reg(1'b0, 2'b01);
    do_hloads(313);
    checks++;
    if (vsc !== 9'd0 || interlace !== 1'b1 || field !== 1'b0) begin
      errors++; $display("FAIL il_apply vsc=%0d il=%b field=%b want 0 1 0", vsc, interlace, field);
    end
    do_hloads(312);
    checks++;
    if (vsc !== 9'd312 || field !== 1'b0) begin
      errors++; $display("FAIL il_f0_last vsc=%0d field=%b want 312 0", vsc, field);
    end
    do_hloads(1);
    checks++;
    if (vsc !== 9'd0 || field !== 1'b1) begin
      errors++; $display("FAIL il_f1_start vsc=%0d field=%b want 0 1", vsc, field);
    end
    do_hloads(311);
    checks++;
    if (vsc !== 9'd311 || field !== 1'b1) begin
      errors++; $display("FAIL il_f1_last vsc=%0d field=%b want 311 1", vsc, field);
    end
    do_hloads(1);
    checks++;
    if (vsc !== 9'd0 || field !== 1'b0 || frame_start !== 1'b1) begin
      errors++; $display("FAIL il_f0_start vsc=%0d field=%b fs=%b want 0 0 1", vsc, field, frame_start);
    end
    do_hloads(312);
    checks++;
    if (vsc !== 9'd312) begin errors++; $display("FAIL il_f0b_last vsc=%0d want 312", vsc); end
    do_hloads(1);
    checks++;
    if (vsc !== 9'd0 || field !== 1'b1) begin
      errors++; $display("FAIL il_f1b_start vsc=%0d field=%b want 0 1", vsc, field);
    end
  endtask

  task automatic test_write_through();
    apply_reset();
    do_hloads(312);
    cpu_we = 1'b1; cpu_sel = 1'b0; cpu_d = 2'b10; hload = 1'b1;
    tick();
    cpu_we = 1'b0; cpu_d = 2'b00; hload = 1'b0;
    checks++;
    if (vsc !== 9'd0 || ntsc !== 1'b1) begin
      errors++; $display("FAIL wt_wrap vsc=%0d ntsc=%b want 0 1", vsc, ntsc);
    end
    do_hloads(262);
    checks++;
    if (vsc !== 9'd262) begin errors++; $display("FAIL wt_ntsc_last vsc=%0d want 262", vsc); end
    do_hloads(1);
    checks++;
    if (vsc !== 9'd0) begin errors++; $display("FAIL wt_ntsc_wrap vsc=%0d want 0", vsc); end
    cpu_we = 1'b1; cpu_sel = 1'b1; cpu_d = 2'b01; hload = 1'b1;
    tick();
    cpu_we = 1'b0; cpu_d = 2'b00; hload = 1'b0;
    checks++;
    if (mde1 !== 1'b1 || vsc !== 9'd1) begin
      errors++; $display("FAIL wt_mono mde1=%b vsc=%0d want 1 1", mde1, vsc);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    write_reg(1'b1, 2'b01);
    do_hloads(200);
    write_reg(1'b0, 2'b11);
    #2 resb = 1'b0;
    #1;
    checks++;
    if (vsc !== 9'd0 || vsync_n !== 1'b0 || field !== 1'b0 || frame_start !== 1'b0 ||
        mde1 !== 1'b0 || mde1b !== 1'b1 || ntsc !== 1'b0 || interlace !== 1'b0) begin
      errors++;
      $display("FAIL async_reset vsc=%0d vsync_n=%b field=%b fs=%b mde1=%b mde1b=%b ntsc=%b il=%b want 0 0 0 0 0 1 0 0",
               vsc, vsync_n, field, frame_start, mde1, mde1b, ntsc, interlace);
    end
    tick();
    resb = 1'b1;
    tick();
    do_hloads(1);
    checks++;
    if (vsc !== 9'd1 || mde1 !== 1'b0) begin
      errors++; $display("FAIL post_reset vsc=%0d mde1=%b want 1 0", vsc, mde1);
    end
    do_hloads(312);
    checks++;
    if (vsc !== 9'd0 || ntsc !== 1'b0 || interlace !== 1'b0) begin
      errors++; $display("FAIL reset_shadow vsc=%0d ntsc=%b il=%b want 0 0 0", vsc, ntsc, interlace);
    end
  endtask

  initial begin
    test_reset();
    test_pal_frame();
    test_ntsc_switch();
    test_mono();
    test_shorten();
    test_interlace();
    test_write_through();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
